// File: rtl/dht11_read_scheduler.sv
// DHT11 read scheduler: periodic read requests, timeout/checksum validation with retry back-off,
// last-good reading hold and display-select toggle. Optional plausibility filter: DHT11_RANGE_CHECK_EN.

module dht11_read_scheduler #(
   parameter int unsigned READ_PERIOD_CYC = 100_000_000,
   parameter int unsigned TIMEOUT_CYC     = 2_500_000,
   parameter int unsigned RETRY_GAP_CYC   = 50_000_000,
   parameter int unsigned MAX_RETRY       = 3,
   parameter int unsigned DISP_CYC        = 134_217_728
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   output logic        start_o,
   input  logic        done_i,
   input  logic [39:0] frame_i,
   output logic [7:0]  temp_o,
   output logic [7:0]  hum_o,
   output logic        valid_o,
   output logic        upd_o,
   output logic        err_o,
   output logic [7:0]  fail_cnt_o,
   output logic        disp_sel_o
);

   localparam int unsigned T_MAX_A = (READ_PERIOD_CYC > TIMEOUT_CYC) ? READ_PERIOD_CYC : TIMEOUT_CYC;
   localparam int unsigned T_MAX   = (T_MAX_A > RETRY_GAP_CYC) ? T_MAX_A : RETRY_GAP_CYC;
   localparam int unsigned TW      = $clog2(T_MAX + 1);
   localparam int unsigned DW      = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;

   localparam logic [TW-1:0] PERIOD_LAST  = TW'(READ_PERIOD_CYC - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] GAP_LAST     = TW'(RETRY_GAP_CYC - 1);
   localparam logic [DW-1:0] DISP_LAST    = DW'(DISP_CYC - 1);
   localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_PERIOD,
      START,
      WAIT_DONE,
      CHECK,
      BACKOFF
   } state_t;

   state_t          state_q;
   logic [TW-1:0]   timer_q;
   logic [3:0]      retry_q;
   logic [3:0]      retry_inc;
   logic [39:0]     frame_p1;
   logic            frame_good;
   logic            timed_out;
   logic            attempt_failed;
   logic            retry_exhausted;
   logic [DW-1:0]   disp_cnt_q;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic csum_ok(input logic [39:0] f);
      logic [7:0] s;
      s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      return s == f[7:0];
   endfunction

`ifdef DHT11_RANGE_CHECK_EN
   // Plausible DHT11 readings: humidity 0..95 %, temperature 0..60 C, no fractional part.
   function automatic logic range_ok(input logic [39:0] f);
      return (f[39:32] <= 8'd95) && (f[23:16] <= 8'd60) &&
             (f[31:24] == 8'd0) && (f[15:8] == 8'd0);
   endfunction

   assign frame_good = csum_ok(frame_p1) && range_ok(frame_p1);
`else
   assign frame_good = csum_ok(frame_p1);
`endif

   // A done pulse on the timeout cycle still counts as an answer.
   assign timed_out       = (state_q == WAIT_DONE) && !done_i && (timer_q == TIMEOUT_LAST);
   assign attempt_failed  = timed_out || ((state_q == CHECK) && !frame_good);
   assign retry_inc       = retry_q + 4'd1;
   assign retry_exhausted = (retry_inc >= RETRY_LIMIT);

   // Stage p1: frame captured on done, checked in CHECK the following cycle.
   always_ff @(posedge clk_i) begin
      if (en_i && (state_q == WAIT_DONE) && done_i) begin
         frame_p1 <= frame_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         retry_q    <= '0;
         start_o    <= 1'b0;
         upd_o      <= 1'b0;
         valid_o    <= 1'b0;
         err_o      <= 1'b0;
         temp_o     <= '0;
         hum_o      <= '0;
         fail_cnt_o <= '0;
      end else begin
         start_o <= 1'b0;
         upd_o   <= 1'b0;
         if (!en_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            retry_q <= '0;
         end else if (attempt_failed) begin
            fail_cnt_o <= sat_inc8(fail_cnt_o);
            timer_q    <= '0;
            if (retry_exhausted) begin
               err_o   <= 1'b1;
               valid_o <= 1'b0;
               retry_q <= '0;
               state_q <= WAIT_PERIOD;
            end else begin
               retry_q <= retry_inc;
               state_q <= BACKOFF;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  timer_q <= '0;
                  state_q <= WAIT_PERIOD;
               end
               WAIT_PERIOD: begin
                  if (timer_q == PERIOD_LAST) begin
                     timer_q <= '0;
                     start_o <= 1'b1;
                     state_q <= START;
                  end else begin
                     timer_q <= timer_q + TW'(1);
                  end
               end
               START: begin
                  timer_q <= '0;
                  state_q <= WAIT_DONE;
               end
               WAIT_DONE: begin
                  if (done_i) begin
                     state_q <= CHECK;
                  end else begin
                     timer_q <= timer_q + TW'(1);
                  end
               end
               CHECK: begin
                  temp_o  <= frame_p1[23:16];
                  hum_o   <= frame_p1[39:32];
                  valid_o <= 1'b1;
                  err_o   <= 1'b0;
                  upd_o   <= 1'b1;
                  retry_q <= '0;
                  timer_q <= '0;
                  state_q <= WAIT_PERIOD;
               end
               BACKOFF: begin
                  if (timer_q == GAP_LAST) begin
                     timer_q <= '0;
                     start_o <= 1'b1;
                     state_q <= START;
                  end else begin
                     timer_q <= timer_q + TW'(1);
                  end
               end
               default: begin
                  timer_q <= '0;
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   // Display alternation runs regardless of the scheduler enable.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         disp_cnt_q <= '0;
         disp_sel_o <= 1'b0;
      end else if (disp_cnt_q == DISP_LAST) begin
         disp_cnt_q <= '0;
         disp_sel_o <= ~disp_sel_o;
      end else begin
         disp_cnt_q <= disp_cnt_q + DW'(1);
      end
   end

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Self-checking bench for dht11_read_scheduler: directed scenarios plus randomized attempts
// checked against a transaction-level model of reading outcomes and request timing.

module tb_dht11_read_scheduler;

   localparam int P  = 100;
   localparam int TO = 20;
   localparam int G  = 10;
   localparam int MR = 3;

   logic        clk = 1'b0;
   logic        rst, en, done;
   logic [39:0] frame;
   logic        start_o, valid_o, upd_o, err_o, disp_sel_o;
   logic [7:0]  temp_o, hum_o, fail_cnt_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] m_temp, m_hum, m_fail;
   logic       m_valid, m_err, m_upd;
   int         m_retry;

   always #5 clk = ~clk;

   dht11_read_scheduler #(
      .READ_PERIOD_CYC(P), .TIMEOUT_CYC(TO), .RETRY_GAP_CYC(G), .MAX_RETRY(MR), .DISP_CYC(16)
   ) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .start_o(start_o), .done_i(done), .frame_i(frame),
      .temp_o(temp_o), .hum_o(hum_o), .valid_o(valid_o), .upd_o(upd_o), .err_o(err_o),
      .fail_cnt_o(fail_cnt_o), .disp_sel_o(disp_sel_o)
   );

   function automatic bit frame_good(input logic [39:0] f);
      int s;
      s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
      frame_good = ((s % 256) == int'(f[7:0]));
`ifdef DHT11_RANGE_CHECK_EN
      if (f[39:32] > 8'd95 || f[23:16] > 8'd60 || f[31:24] != 8'd0 || f[15:8] != 8'd0)
         frame_good = 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_temp = 0; m_hum = 0; m_fail = 0; m_valid = 0; m_err = 0; m_upd = 0; m_retry = 0;
   endtask

   // Outcome of one attempt; gap = cycles from the result becoming visible to the next request.
   task automatic model_outcome(input bit good, input logic [39:0] f, output int gap);
      if (good) begin
         m_temp = f[23:16]; m_hum = f[39:32]; m_valid = 1; m_err = 0; m_upd = 1; m_retry = 0;
         gap = P;
      end else begin
         m_fail = (int'(m_fail) >= 255) ? 8'd255 : m_fail + 8'd1;
         m_upd = 0;
         m_retry++;
         if (m_retry < MR) gap = G;
         else begin m_err = 1; m_valid = 0; m_retry = 0; gap = P; end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; en = 0; done = 0; frame = '0;
      repeat (2) @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   task automatic wait_start(input int limit, output int n);
      bit seen;
      seen = 0;
      n = -1;
      for (int i = 1; i <= limit && !seen; i++) begin
         @(negedge clk);
         if (start_o === 1'b1) begin n = i; seen = 1; end
      end
   endtask

   task automatic pulse_done(input logic [39:0] f);
      done = 1; frame = f;
      @(negedge clk);
      done = 0; frame = 40'({$urandom(), $urandom()});
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1; en = 1; done = 0; frame = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (start_o !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %0b want 0", start_o); end
      end
      n_cmp++;
      if ({upd_o, valid_o, err_o, disp_sel_o, temp_o, hum_o, fail_cnt_o} !== 28'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %h want 0", {upd_o, valid_o, err_o, disp_sel_o, temp_o, hum_o, fail_cnt_o});
      end
      rst = 0; en = 0;
   endtask

   task automatic test_disp_sel();
      do_reset();
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         n_cmp++;
         if (disp_sel_o !== 1'((i / 16) % 2)) begin
            n_bad++; $display("FAIL disp_sel cycle %0d: got %0b want %0b", i, disp_sel_o, (i / 16) % 2);
         end
      end
   endtask

   task automatic test_first_read();
      int n;
      do_reset();
      en = 1;
      wait_start(P + 10, n);
      n_cmp++; if (n !== P + 1) begin n_bad++; $display("FAIL first_start: got %0d want %0d", n, P + 1); end
      repeat (5) @(negedge clk);
      pulse_done(40'h3700190050);
      n_cmp++; if ({upd_o, valid_o} !== 2'b00) begin n_bad++; $display("FAIL first_early: got %b want 00", {upd_o, valid_o}); end
      @(negedge clk);
      n_cmp++;
      if ({temp_o, hum_o, valid_o, upd_o, err_o, fail_cnt_o} !== {8'd25, 8'd55, 1'b1, 1'b1, 1'b0, 8'd0}) begin
         n_bad++; $display("FAIL first_read: got t=%0d h=%0d v=%0b u=%0b e=%0b f=%0d want 25 55 1 1 0 0",
                           temp_o, hum_o, valid_o, upd_o, err_o, fail_cnt_o);
      end
      @(negedge clk);
      n_cmp++; if (upd_o !== 1'b0) begin n_bad++; $display("FAIL upd_width: got %0b want 0", upd_o); end
      wait_start(P + 10, n);
      n_cmp++; if (n !== P - 1) begin n_bad++; $display("FAIL period_after_good: got %0d want %0d", n, P - 1); end
   endtask

   task automatic test_bad_checksum();
      int n;
      repeat (3) @(negedge clk);
      pulse_done(40'h3700190051);
      @(negedge clk);
      n_cmp++;
      if ({fail_cnt_o, upd_o, valid_o, err_o} !== {8'd1, 1'b0, 1'b1, 1'b0}) begin
         n_bad++; $display("FAIL bad_csum: got f=%0d u=%0b v=%0b e=%0b want 1 0 1 0", fail_cnt_o, upd_o, valid_o, err_o);
      end
      wait_start(G + 5, n);
      n_cmp++; if (n !== G) begin n_bad++; $display("FAIL retry_gap: got %0d want %0d", n, G); end
      repeat (2) @(negedge clk);
      pulse_done(40'h3700190050);
      @(negedge clk);
      n_cmp++;
      if ({valid_o, upd_o, fail_cnt_o} !== {1'b1, 1'b1, 8'd1}) begin
         n_bad++; $display("FAIL retry_good: got v=%0b u=%0b f=%0d want 1 1 1", valid_o, upd_o, fail_cnt_o);
      end
      wait_start(P + 5, n);
      for (int a = 1; a <= 2; a++) begin
         @(negedge clk);
         pulse_done(40'h3700190051);
         @(negedge clk);
         n_cmp++;
         if ({err_o, fail_cnt_o} !== {1'b0, 8'(1 + a)}) begin
            n_bad++; $display("FAIL retry_cleared %0d: got e=%0b f=%0d want 0 %0d", a, err_o, fail_cnt_o, 1 + a);
         end
         wait_start(P + 5, n);
         n_cmp++; if (n !== G) begin n_bad++; $display("FAIL retry_cleared_gap %0d: got %0d want %0d", a, n, G); end
      end
   endtask

   task automatic test_timeout_err();
      int n;
      do_reset();
      en = 1;
      wait_start(P + 10, n);
      repeat (4) @(negedge clk);
      pulse_done(40'h30001A004A);
      @(negedge clk);
      n_cmp++;
      if ({temp_o, hum_o, valid_o} !== {8'd26, 8'd48, 1'b1}) begin
         n_bad++; $display("FAIL pre_timeout_read: got t=%0d h=%0d v=%0b want 26 48 1", temp_o, hum_o, valid_o);
      end
      wait_start(P + 5, n);
      for (int a = 1; a <= 3; a++) begin
         repeat (TO + 1) @(negedge clk);
         n_cmp++;
         if ({fail_cnt_o, err_o, valid_o, upd_o, temp_o, hum_o} !== {8'(a), a == 3, a != 3, 1'b0, 8'd26, 8'd48}) begin
            n_bad++; $display("FAIL timeout %0d: got f=%0d e=%0b v=%0b u=%0b t=%0d h=%0d want %0d %0b %0b 0 26 48",
                              a, fail_cnt_o, err_o, valid_o, upd_o, temp_o, hum_o, a, a == 3, a != 3);
         end
         wait_start(P + 5, n);
         n_cmp++; if (n !== ((a < 3) ? G : P)) begin n_bad++; $display("FAIL timeout_gap %0d: got %0d want %0d", a, n, (a < 3) ? G : P); end
      end
      repeat (7) @(negedge clk);
      pulse_done(40'h3700190050);
      @(negedge clk);
      n_cmp++;
      if ({err_o, valid_o, temp_o, fail_cnt_o} !== {1'b0, 1'b1, 8'd25, 8'd3}) begin
         n_bad++; $display("FAIL err_clear: got e=%0b v=%0b t=%0d f=%0d want 0 1 25 3", err_o, valid_o, temp_o, fail_cnt_o);
      end
   endtask

   task automatic test_coincide_ignore();
      int n;
      do_reset();
      en = 1;
      repeat (30) @(negedge clk);
      pulse_done(40'h3700190050);
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({valid_o, upd_o, fail_cnt_o} !== 10'd0) begin
         n_bad++; $display("FAIL done_in_wait_period: got v=%0b u=%0b f=%0d want 0 0 0", valid_o, upd_o, fail_cnt_o);
      end
      wait_start(P + 10, n);
      n_cmp++; if (n !== P + 1 - 33) begin n_bad++; $display("FAIL start_after_ignore: got %0d want %0d", n, P + 1 - 33); end
      repeat (TO) @(negedge clk);
      pulse_done(40'h2A0014003E);
      @(negedge clk);
      n_cmp++;
      if ({valid_o, upd_o, temp_o, hum_o, fail_cnt_o} !== {1'b1, 1'b1, 8'd20, 8'd42, 8'd0}) begin
         n_bad++; $display("FAIL done_at_timeout: got v=%0b u=%0b t=%0d h=%0d f=%0d want 1 1 20 42 0",
                           valid_o, upd_o, temp_o, hum_o, fail_cnt_o);
      end
      wait_start(P + 5, n);
      repeat (TO + 1) @(negedge clk);
      n_cmp++; if (fail_cnt_o !== 8'd1) begin n_bad++; $display("FAIL late_done_timeout: got %0d want 1", fail_cnt_o); end
      pulse_done(40'h3700190050);
      @(negedge clk);
      n_cmp++;
      if ({temp_o, upd_o, fail_cnt_o} !== {8'd20, 1'b0, 8'd1}) begin
         n_bad++; $display("FAIL late_done_ignored: got t=%0d u=%0b f=%0d want 20 0 1", temp_o, upd_o, fail_cnt_o);
      end
      wait_start(G + 5, n);
      n_cmp++; if (n !== G - 2) begin n_bad++; $display("FAIL late_done_gap: got %0d want %0d", n, G - 2); end
   endtask

   task automatic test_disable();
      int n;
      do_reset();
      en = 1;
      wait_start(P + 10, n);
      repeat (2) @(negedge clk);
      pulse_done(40'h3700190050);
      wait_start(P + 5, n);
      repeat (2) @(negedge clk);
      pulse_done(40'h3700190051);
      wait_start(G + 5, n);
      repeat (3) @(negedge clk);
      en = 0;
      @(negedge clk);
      pulse_done(40'h2A0014003E);
      @(negedge clk);
      n_cmp++;
      if ({temp_o, hum_o, valid_o, upd_o, fail_cnt_o} !== {8'd25, 8'd55, 1'b1, 1'b0, 8'd1}) begin
         n_bad++; $display("FAIL disabled_hold: got t=%0d h=%0d v=%0b u=%0b f=%0d want 25 55 1 0 1",
                           temp_o, hum_o, valid_o, upd_o, fail_cnt_o);
      end
      wait_start(150, n);
      n_cmp++; if (n !== -1) begin n_bad++; $display("FAIL disabled_start: got %0d want -1", n); end
      en = 1;
      wait_start(P + 10, n);
      n_cmp++; if (n !== P + 1) begin n_bad++; $display("FAIL reenable_start: got %0d want %0d", n, P + 1); end
      for (int a = 1; a <= 2; a++) begin
         @(negedge clk);
         pulse_done(40'h3700190051);
         @(negedge clk);
         wait_start(P + 5, n);
      end
      n_cmp++;
      if ({err_o, fail_cnt_o, n} !== {1'b0, 8'd3, G}) begin
         n_bad++; $display("FAIL disable_clears_retry: got e=%0b f=%0d gap=%0d want 0 3 %0d", err_o, fail_cnt_o, n, G);
      end
   endtask

   task automatic test_reset_backoff();
      int n;
      do_reset();
      en = 1;
      wait_start(P + 10, n);
      @(negedge clk);
      pulse_done(40'h3700190050);
      wait_start(P + 5, n);
      @(negedge clk);
      pulse_done(40'h3700190051);
      @(negedge clk);
      n_cmp++;
      if ({valid_o, fail_cnt_o} !== {1'b1, 8'd1}) begin
         n_bad++; $display("FAIL pre_reset_state: got v=%0b f=%0d want 1 1", valid_o, fail_cnt_o);
      end
      repeat (3) @(negedge clk);
      rst = 1;
      @(negedge clk);
      n_cmp++;
      if ({start_o, upd_o, valid_o, err_o, disp_sel_o, temp_o, hum_o, fail_cnt_o} !== 29'd0) begin
         n_bad++; $display("FAIL reset_in_backoff: got %h want 0", {start_o, upd_o, valid_o, err_o, disp_sel_o, temp_o, hum_o, fail_cnt_o});
      end
      rst = 0; en = 0;
   endtask

   task automatic test_range();
      int n, gap;
      logic [39:0] frames [4] = '{40'h640019007D, 40'h28003D0065, 40'h3201140047, 40'h5F003C009B};
      do_reset();
      en = 1;
      wait_start(P + 10, n);
      for (int i = 0; i < 4; i++) begin
         repeat (2) @(negedge clk);
         pulse_done(frames[i]);
         @(negedge clk);
         model_outcome(frame_good(frames[i]), frames[i], gap);
         n_cmp++;
         if ({temp_o, hum_o, valid_o, err_o, fail_cnt_o, upd_o} !== {m_temp, m_hum, m_valid, m_err, m_fail, m_upd}) begin
            n_bad++; $display("FAIL range %0d: got %h want %h", i,
                              {temp_o, hum_o, valid_o, err_o, fail_cnt_o, upd_o}, {m_temp, m_hum, m_valid, m_err, m_fail, m_upd});
         end
         wait_start(gap + 5, n);
         n_cmp++; if (n !== gap) begin n_bad++; $display("FAIL range_gap %0d: got %0d want %0d", i, n, gap); end
      end
   endtask

   task automatic test_random();
      int n, gap, k;
      logic [7:0] h, hd, t, td, cs;
      logic [39:0] f;
      do_reset();
      en = 1;
      wait_start(P + 10, n);
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat (TO + 1) @(negedge clk);
            model_outcome(1'b0, 40'd0, gap);
         end else begin
            k  = $urandom_range(1, TO);
            h  = 8'($urandom_range(0, 99));
            t  = 8'($urandom_range(0, 63));
            hd = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'd0;
            td = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'd0;
            cs = 8'((int'(h) + int'(hd) + int'(t) + int'(td)) % 256);
            if ($urandom_range(0, 2) == 0) cs = cs + 8'($urandom_range(1, 255));
            f = {h, hd, t, td, cs};
            repeat (k) @(negedge clk);
            pulse_done(f);
            @(negedge clk);
            model_outcome(frame_good(f), f, gap);
         end
         n_cmp++;
         if ({temp_o, hum_o, valid_o, err_o, fail_cnt_o, upd_o} !== {m_temp, m_hum, m_valid, m_err, m_fail, m_upd}) begin
            n_bad++; $display("FAIL random %0d: got %h want %h", it,
                              {temp_o, hum_o, valid_o, err_o, fail_cnt_o, upd_o}, {m_temp, m_hum, m_valid, m_err, m_fail, m_upd});
         end
         wait_start(gap + 5, n);
         n_cmp++; if (n !== gap) begin n_bad++; $display("FAIL random_gap %0d: got %0d want %0d", it, n, gap); end
      end
   endtask

   task automatic test_saturation();
      int n, gap;
      do_reset();
      en = 1;
      wait_start(P + 10, n);
      for (int a = 1; a <= 260; a++) begin
         @(negedge clk);
         pulse_done(40'h3700190051);
         @(negedge clk);
         model_outcome(1'b0, 40'd0, gap);
         if (a >= 254) begin
            n_cmp++;
            if (fail_cnt_o !== m_fail) begin n_bad++; $display("FAIL saturation %0d: got %0d want %0d", a, fail_cnt_o, m_fail); end
         end
         wait_start(gap + 5, n);
         if (n !== gap) begin
            n_cmp++; n_bad++;
            $display("FAIL saturation_gap %0d: got %0d want %0d", a, n, gap);
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1; en = 0; done = 0; frame = '0;
      model_reset();
      test_reset();
      test_disp_sel();
      test_first_read();
      test_bad_checksum();
      test_timeout_err();
      test_coincide_ignore();
      test_disable();
      test_reset_backoff();
      test_range();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
